keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk cycles each column is driven while scanning.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20000, clk cycles a press or release must be stable.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col_out  output  4  keypad columns, one-hot-low drive (exactly one bit 0).
REQ-007 SHALL have port key_code  output  4  code of the debounced key: 0-9 digits, A=1010, B=1011, C=1100, D=1101, *=1110, #=1111.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a new debounced press is accepted.
REQ-009 SHALL have port key_held  output  1  high from key_valid until the debounced release.

Function
REQ-010 SHALL pass row_in through a 2-flop synchronizer before any use.
REQ-011 SHALL use key map row0: 1 2 3 A; row1: 4 5 6 B; row2: 7 8 9 C; row3: * 0 # D (columns 0..3 left to right).
REQ-012 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-013 In SCAN, SHALL rotate the low bit of col_out 0->1->2->3->0 every SCAN_DIV cycles.
REQ-014 In SCAN, any synchronized row low SHALL latch column and lowest-index low row, freeze col_out, clear the counter and go to DEBOUNCE.
REQ-015 In DEBOUNCE, SHALL count cycles while the latched row stays low; reaching DEBOUNCE_CYCLES-1 SHALL go to PRESSED.
REQ-016 In DEBOUNCE, the latched row going high SHALL return to SCAN with no output, resuming scan from the next column.
REQ-017 On entry to PRESSED, SHALL update key_code and pulse key_valid for exactly one cycle; key_held SHALL rise in the same cycle.
REQ-018 In PRESSED, col_out SHALL stay frozen; the latched row going high SHALL clear the counter and go to RELEASE.
REQ-019 In RELEASE, the latched row staying high for DEBOUNCE_CYCLES cycles SHALL clear key_held and go to SCAN; going low again SHALL return to PRESSED without a new key_valid.
REQ-020 Additional keys pressed while in DEBOUNCE, PRESSED or RELEASE SHALL be ignored (no rollover).
REQ-021 key_code SHALL hold its last value until the next accepted press.
REQ-022 Counters SHALL be sized $clog2 of the larger parameter and SHALL saturate; no wrap-around.
REQ-023 Latency from a stable row change at the pins to key_valid SHALL be 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle.

Reset
REQ-024 While rst_n is 0: state=SCAN, col_out=4'b1110, key_code=4'b0000, key_valid=0, key_held=0, counters=0, synchronizer=4'b1111.
REQ-025 Reset asserted mid-press SHALL drop key_held immediately with no key_valid; after release of reset a still-pressed key SHALL be re-debounced and reported once.

Structure
REQ-026 Shared package keypad_pkg SHALL hold the key-code constants (KEY_0..KEY_9, KEY_A..KEY_D, KEY_STAR, KEY_HASH) and the FSM state typedef, shared with the key classifier downstream.
REQ-027 Synchronizer SHALL be one sub-module, row_sync (4-bit, 2-flop, async reset to all-ones).

Verification (bench uses SCAN_DIV=4, DEBOUNCE_CYCLES=16)
REQ-028 Reset, no keys -> col_out cycles 1110,1101,1011,0111 every 4 clk; key_valid never asserts.
REQ-029 Hold row1 low only when col2 driven, 100 cycles -> one key_valid, key_code=4'b0110 (6), key_held high until 16+2 cycles after release.
REQ-030 Row3/col3 with 5-cycle bounce pulses before a stable press -> exactly one key_valid, key_code=4'b1101 (D).
REQ-031 Row2/col0 low for 10 cycles only -> no key_valid, scan resumes at col1.
REQ-032 Hold 5 (row1/col1), then also press 9 -> single key_valid code 4'b0101; after full release, press 9 alone -> key_code=4'b1001.
REQ-033 Assert rst_n=0 during PRESSED with key held -> key_held=0 immediately; after reset release, one new key_valid with same code.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key-code constants, scanner FSM state type and
// small helpers used by the scanner and the downstream key classifier.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Counter width covering the larger of two cycle counts (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Lowest-index row that reads low; rows are active-low.
    function automatic logic [1:0] first_low(input logic [3:0] rows);
        casez (rows)
            4'b???0: return 2'd0;
            4'b??01: return 2'd1;
            4'b?011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'b00_00: return KEY_1;
            4'b00_01: return KEY_2;
            4'b00_10: return KEY_3;
            4'b00_11: return KEY_A;
            4'b01_00: return KEY_4;
            4'b01_01: return KEY_5;
            4'b01_10: return KEY_6;
            4'b01_11: return KEY_B;
            4'b10_00: return KEY_7;
            4'b10_01: return KEY_8;
            4'b10_10: return KEY_9;
            4'b10_11: return KEY_C;
            4'b11_00: return KEY_STAR;
            4'b11_01: return KEY_0;
            4'b11_10: return KEY_HASH;
            default:  return KEY_D;
        endcase
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module row_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounce of press and release,
// single-key (no rollover) reporting of a key code with valid/held flags.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned CW = cnt_width(SCAN_DIV, DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    kp_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    col_idx, col_idx_nxt;
    logic [1:0]    lrow, lrow_nxt;
    logic [3:0]    row_s;
    logic          row_low;
    logic          accept;

    row_sync u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_in),
        .q     (row_s)
    );

    assign row_low = ~row_s[lrow];
    assign accept  = (state == DEBOUNCE) && (state_nxt == PRESSED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            cnt       <= '0;
            col_idx   <= '0;
            lrow      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            col_idx   <= col_idx_nxt;
            lrow      <= lrow_nxt;
            key_valid <= accept;
            if (accept)
                key_code <= key_lookup(lrow, col_idx);
        end
    end

    // One counter serves as scan divider in SCAN and debounce timer elsewhere.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (cnt == '1) ? cnt : cnt + 1'b1;
        col_idx_nxt = col_idx;
        lrow_nxt    = lrow;
        case (state)
            SCAN: begin
                if (row_s != 4'b1111) begin
                    lrow_nxt  = first_low(row_s);
                    cnt_nxt   = '0;
                    state_nxt = DEBOUNCE;
                end else if (cnt >= SCAN_LAST) begin
                    cnt_nxt     = '0;
                    col_idx_nxt = col_idx + 2'd1;
                end
            end
            DEBOUNCE: begin
                if (!row_low) begin
                    cnt_nxt     = '0;
                    col_idx_nxt = col_idx + 2'd1;
                    state_nxt   = SCAN;
                end else if (cnt >= DB_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                cnt_nxt = '0;
                if (!row_low)
                    state_nxt = RELEASE;
            end
            RELEASE: begin
                if (row_low) begin
                    cnt_nxt   = '0;
                    state_nxt = PRESSED;
                end else if (cnt >= DB_LAST) begin
                    cnt_nxt     = '0;
                    col_idx_nxt = col_idx + 2'd1;
                    state_nxt   = SCAN;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = SCAN;
            end
        endcase
    end

    always_comb begin
        col_out          = '1;
        col_out[col_idx] = 1'b0;
        key_held         = (state == PRESSED) || (state == RELEASE);
    end

endmodule
